score_display_scanner: RTL

//  Consumes the divided 10 kHz scan clock and 2 Hz blink clock from the frequency divider and drives a
//  4-digit multiplexed 7-segment display showing the Bricks score. It converts the binary score to BCD
//  (sequential double-dabble), blanks leading zeros, scans one digit per scan edge and blinks masked digits.

---
 rtl/score_display_scanner.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/score_display_scanner.sv
// rtl/score_display_scanner.sv - binary score to BCD, leading-zero blanking, 4-digit 7-segment scan with blink
module score_display_scanner #(
    parameter int SAT_MAX     = 9999,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        scan_clk,
    input  logic        blink_clk,
    input  logic [13:0] score,
    input  logic        score_valid,
    input  logic [3:0]  blink_mask,
    output logic        busy,
    output logic [7:0]  seg,
    output logic [3:0]  digit_en
);

    localparam logic [13:0] SAT = 14'(SAT_MAX);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                 state, next_state;
    logic [SYNC_STAGES-1:0] scan_sync, blink_sync;
    logic                   scan_prev;
    logic                   scan_tick, blink_on;
    logic [13:0]            shift_reg, pend_val, score_sat, load_val;
    logic [15:0]            bcd, bcd_adj, digits;
    logic [3:0]             iter;
    logic                   pend_v, load;
    logic [1:0]             index;
    logic [3:0]             cur_digit;
    logic                   lead_blank;
    logic [7:0]             seg_next;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 8'hC0;
            4'd1:    seg7 = 8'hF9;
            4'd2:    seg7 = 8'hA4;
            4'd3:    seg7 = 8'hB0;
            4'd4:    seg7 = 8'h99;
            4'd5:    seg7 = 8'h92;
            4'd6:    seg7 = 8'h82;
            4'd7:    seg7 = 8'hF8;
            4'd8:    seg7 = 8'h80;
            4'd9:    seg7 = 8'h90;
            default: seg7 = 8'hFF;
        endcase
    endfunction

    // Divided clocks are treated as asynchronous data and only ever sampled.
    always_ff @(posedge clock) begin
        if (!reset) begin
            scan_sync  <= '0;
            blink_sync <= '0;
            scan_prev  <= 1'b0;
        end else begin
            scan_sync  <= {scan_sync[SYNC_STAGES-2:0], scan_clk};
            blink_sync <= {blink_sync[SYNC_STAGES-2:0], blink_clk};
            scan_prev  <= scan_sync[SYNC_STAGES-1];
        end
    end

    assign scan_tick = scan_sync[SYNC_STAGES-1] & ~scan_prev;
    assign blink_on  = blink_sync[SYNC_STAGES-1];
    assign score_sat = (score > SAT) ? SAT : score;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (score_valid) next_state = SHIFT;
            SHIFT:   if (iter == 4'd13) next_state = DONE;
            DONE:    next_state = (score_valid || pend_v) ? SHIFT : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        load     = ((state == IDLE) && score_valid) || ((state == DONE) && (score_valid || pend_v));
        load_val = score_valid ? score_sat : pend_val;
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            bcd_adj[k*4 +: 4] = (bcd[k*4 +: 4] >= 4'd5) ? bcd[k*4 +: 4] + 4'd3 : bcd[k*4 +: 4];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            shift_reg <= '0;
            bcd       <= '0;
            iter      <= '0;
            pend_v    <= 1'b0;
            pend_val  <= '0;
            digits    <= '0;
        end else begin
            if (load) begin
                shift_reg <= load_val;
                bcd       <= '0;
                iter      <= '0;
            end else if (state == SHIFT) begin
                bcd       <= {bcd_adj[14:0], shift_reg[13]};
                shift_reg <= {shift_reg[12:0], 1'b0};
                iter      <= iter + 4'd1;
            end
            // All four digits are replaced in one cycle so the scan never mixes old and new values.
            if (state == DONE) begin
                digits <= bcd;
            end
            // The DONE cycle consumes whatever is newest, so pending always empties there.
            if (state == DONE) begin
                pend_v <= 1'b0;
            end else if (busy && score_valid) begin
                pend_v   <= 1'b1;
                pend_val <= score_sat;
            end
        end
    end

    always_comb begin
        cur_digit = digits[{index, 2'b00} +: 4];
        case (index)
            2'd1:    lead_blank = (digits[15:4] == 12'd0);
            2'd2:    lead_blank = (digits[15:8] == 8'd0);
            2'd3:    lead_blank = (digits[15:12] == 4'd0);
            default: lead_blank = 1'b0;
        endcase
        if (lead_blank || (blink_mask[index] && !blink_on)) begin
            seg_next = 8'hFF;
        end else begin
            seg_next = seg7(cur_digit);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            index    <= 2'd0;
            seg      <= 8'hFF;
            digit_en <= 4'b1111;
        end else begin
            index    <= index + {1'b0, scan_tick};
            seg      <= seg_next;
            digit_en <= ~(4'b0001 << index);
        end
    end

endmodule
